tour_cmd: RTL and testbench
===========================

# tour_cmd

Command multiplexer and tour sequencer between the UART command path and the motion controller. In idle it passes UART commands straight through. Once a tour starts, it walks 24 knight moves supplied by the tour solver. Each move is issued as two motion commands: a vertical leg, then a horizontal leg, each gated by the controller's handshake.

## Interface
- No parameters.
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high, `rst`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_tour`  in  1  one-cycle pulse from the solver; the solution is ready.
- `move`  in  8  one-hot knight move at index `mv_indx`, from the solver.
- `mv_indx`  out  5  index (0..23) of the move being executed.
- `cmd_UART`  in  16  command from the UART/wrapper.
- `cmd_rdy_UART`  in  1  `cmd_UART` is valid.
- `cmd`  out  16  command to the motion controller.
- `cmd_rdy`  out  1  `cmd` is valid.
- `clr_cmd_rdy`  in  1  the controller has consumed `cmd`.
- `send_resp`  in  1  the controller has finished the command.
- `resp`  out  8  response byte for the UART.

## Operation
- Command format: `[15:12]` opcode, `[11:4]` heading, `[3:0]` square count.
- Move opcode is 4'h2.
- Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- States:
  - IDLE
  - VERT: vertical command valid
  - VWAIT: wait for vertical completion
  - HORZ: horizontal command valid
  - HWAIT: wait for horizontal completion
- IDLE:
  - `cmd` = `cmd_UART`, `cmd_rdy` = `cmd_rdy_UART`.
  - `start_tour` clears `mv_indx` to 0 and moves to VERT.
- VERT: `cmd` = vertical command, `cmd_rdy` = 1. On `clr_cmd_rdy`, go to VWAIT.
- VWAIT: `cmd` holds the vertical command, `cmd_rdy` = 0. On `send_resp`, go to HORZ.
- HORZ: `cmd` = horizontal command, `cmd_rdy` = 1. On `clr_cmd_rdy`, go to HWAIT.
- HWAIT: `cmd` holds the horizontal command, `cmd_rdy` = 0. On `send_resp`:
  - if `mv_indx` == 23, go to IDLE;
  - otherwise increment `mv_indx` and go to VERT.
- Move decode, listed as bit: (vertical cmd, horizontal cmd):
  - 0: 2002, 2BF1
  - 1: 2002, 23F1
  - 2: 2001, 23F2
  - 3: 27F1, 23F2
  - 4: 27F2, 23F1
  - 5: 27F2, 2BF1
  - 6: 27F1, 2BF2
  - 7: 2001, 2BF2
- A `move` that is not one-hot issues 16'h2000 and 16'h2BF0 (zero squares).
- `resp`:
  - 8'hA5 in IDLE, and in HWAIT when `mv_indx` == 23 (tour done);
  - 8'h5A in all other tour states.
- Ignored inputs:
  - `start_tour` outside IDLE.
  - `clr_cmd_rdy` and `send_resp` in IDLE.
  - `send_resp` in VERT/HORZ.
  - `clr_cmd_rdy` in VWAIT/HWAIT.
- `mv_indx` never exceeds 23.

## Timing
- Reset values: state IDLE, `mv_indx` = 0, `resp` = 8'hA5. `cmd`/`cmd_rdy` mirror `cmd_UART`/`cmd_rdy_UART`.
- `cmd`, `cmd_rdy` and `resp` are combinational from the registered state, `mv_indx` and `move`. No extra pipeline stage.
- `start_tour` seen high at edge N: the vertical command with `cmd_rdy` = 1 is valid right after edge N.
- `send_resp` seen high at edge N in VWAIT: the horizontal command is valid right after edge N.
- `send_resp` seen high in HWAIT: `mv_indx` increments at that edge, and the next vertical command (decoded from the new `move`) is valid in the same cycle.
- The solver must present `move` for the new `mv_indx` combinationally or within the same cycle.
- Reset asserted mid-tour returns to IDLE immediately, with `mv_indx` = 0.

## Structure
- Shared package: opcode constant (4'h2), the four heading constants, and the state enum.
- One combinational sub-module, `tour_move_decode`: `move[7:0]` in, `vert_cmd[15:0]` and `horz_cmd[15:0]` out.
- Top level holds the FSM, the `mv_indx` counter and the output muxes.

## Test plan
- Reset, then drive `cmd_UART` = 16'h1234 with `cmd_rdy_UART` = 1 -> `cmd` = 1234, `cmd_rdy` = 1, `resp` = A5.
- `start_tour` pulse with `move` = 1<<`mv_indx` -> `cmd` = 2002, `cmd_rdy` = 1. Then `clr_cmd_rdy` -> `cmd_rdy` = 0. Then `send_resp` -> `cmd` = 2BF1.
- Continue the handshakes for `mv_indx` 1..7 -> vertical/horizontal pairs exactly as the decode list; `resp` = 5A throughout.
- Run all 24 moves -> after the final `send_resp`, state is IDLE and `cmd` mirrors `cmd_UART`; `resp` = A5 in the final HWAIT.
- Pulse `start_tour` in VWAIT -> no change. Assert `rst` mid-tour -> IDLE, `mv_indx` = 0.
- Drive `move` = 8'h03 (not one-hot) -> 2000, then 2BF0.

Source files
------------

// File: rtl/tour_cmd_pkg.sv
// Shared constants for the tour command multiplexer: command fields, headings,
// responses and FSM state encodings.
package tour_cmd_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned RESP_W = 8;
  localparam int unsigned MOVE_W = 8;

  localparam logic [3:0] OP_MOVE = 4'h2;

  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  localparam logic [IDX_W-1:0]  LAST_IDX  = 5'd23;
  localparam logic [RESP_W-1:0] RESP_DONE = 8'hA5;
  localparam logic [RESP_W-1:0] RESP_BUSY = 8'h5A;

  // Tour FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_VERT  = 3'd1;
  localparam logic [2:0] ST_VWAIT = 3'd2;
  localparam logic [2:0] ST_HORZ  = 3'd3;
  localparam logic [2:0] ST_HWAIT = 3'd4;

  function automatic logic [CMD_W-1:0] mk_move_cmd(input logic [7:0] hdg,
                                                   input logic [3:0] squares);
    return {OP_MOVE, hdg, squares};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into its vertical and horizontal motion commands;
// anything not one-hot becomes a pair of zero-length moves.
module tour_move_decode
  import tour_cmd_pkg::*;
(
  input  logic [MOVE_W-1:0] move,
  output logic [CMD_W-1:0]  vert_cmd,
  output logic [CMD_W-1:0]  horz_cmd
);

  always_comb begin
    vert_cmd = mk_move_cmd(HDG_NORTH, 4'd0);
    horz_cmd = mk_move_cmd(HDG_EAST, 4'd0);
    case (move)
      8'h01: begin vert_cmd = mk_move_cmd(HDG_NORTH, 4'd2); horz_cmd = mk_move_cmd(HDG_EAST, 4'd1); end
      8'h02: begin vert_cmd = mk_move_cmd(HDG_NORTH, 4'd2); horz_cmd = mk_move_cmd(HDG_WEST, 4'd1); end
      8'h04: begin vert_cmd = mk_move_cmd(HDG_NORTH, 4'd1); horz_cmd = mk_move_cmd(HDG_WEST, 4'd2); end
      8'h08: begin vert_cmd = mk_move_cmd(HDG_SOUTH, 4'd1); horz_cmd = mk_move_cmd(HDG_WEST, 4'd2); end
      8'h10: begin vert_cmd = mk_move_cmd(HDG_SOUTH, 4'd2); horz_cmd = mk_move_cmd(HDG_WEST, 4'd1); end
      8'h20: begin vert_cmd = mk_move_cmd(HDG_SOUTH, 4'd2); horz_cmd = mk_move_cmd(HDG_EAST, 4'd1); end
      8'h40: begin vert_cmd = mk_move_cmd(HDG_SOUTH, 4'd1); horz_cmd = mk_move_cmd(HDG_EAST, 4'd2); end
      8'h80: begin vert_cmd = mk_move_cmd(HDG_NORTH, 4'd1); horz_cmd = mk_move_cmd(HDG_EAST, 4'd2); end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Passes UART commands through in idle; during a tour, sequences 24 knight moves
// as vertical/horizontal command pairs gated by the motion controller handshake.
module tour_cmd
  import tour_cmd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_tour,
  input  logic [MOVE_W-1:0]   move,
  output logic [IDX_W-1:0]    mv_indx,
  input  logic [CMD_W-1:0]    cmd_UART,
  input  logic                cmd_rdy_UART,
  output logic [CMD_W-1:0]    cmd,
  output logic                cmd_rdy,
  input  logic                clr_cmd_rdy,
  input  logic                send_resp,
  output logic [RESP_W-1:0]   resp
);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [CMD_W-1:0] vert_cmd;
  logic [CMD_W-1:0] horz_cmd;
  logic             last_move;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  assign last_move = (mv_indx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mv_indx <= '0;
    end else begin
      state   <= state_nxt;
      mv_indx <= idx_nxt;
    end
  end

  // Next state and move index; inputs not listed per state are ignored
  always_comb begin
    state_nxt = state;
    idx_nxt   = mv_indx;
    case (state)
      ST_IDLE: begin
        if (start_tour) begin
          state_nxt = ST_VERT;
          idx_nxt   = '0;
        end
      end
      ST_VERT:  if (clr_cmd_rdy) state_nxt = ST_VWAIT;
      ST_VWAIT: if (send_resp)   state_nxt = ST_HORZ;
      ST_HORZ:  if (clr_cmd_rdy) state_nxt = ST_HWAIT;
      ST_HWAIT: begin
        if (send_resp) begin
          if (last_move) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_VERT;
            idx_nxt   = IDX_W'(mv_indx + IDX_W'(1));
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output muxes straight from the registered state, so no extra latency
  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = cmd_rdy_UART;
    resp    = RESP_BUSY;
    case (state)
      ST_IDLE:  resp = RESP_DONE;
      ST_VERT:  begin cmd = vert_cmd; cmd_rdy = 1'b1; end
      ST_VWAIT: begin cmd = vert_cmd; cmd_rdy = 1'b0; end
      ST_HORZ:  begin cmd = horz_cmd; cmd_rdy = 1'b1; end
      ST_HWAIT: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b0;
        if (last_move) resp = RESP_DONE;
      end
      default:  resp = RESP_DONE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized bench for tour_cmd; expected commands come from knight-move
// displacements turned into heading/distance pairs.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  tour_moves [32];
  logic        use_tour;
  logic [7:0]  move_force;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // The solver presents the move for the current index combinationally
  assign move = use_tour ? tour_moves[mv_indx] : move_force;

  tour_cmd dut (
    .clk          (clk),
    .rst          (rst),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp)
  );

  // Knight displacement per move bit: north and east positive
  function automatic void ref_legs(input logic [7:0] m,
                                  output logic [15:0] v, output logic [15:0] h);
    int dys [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int dxs [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy = 0;
    int dx = 0;
    int ady, adx;
    if ($countones(m) == 1) begin
      for (int b = 0; b < 8; b++) begin
        if (m[b]) begin
          dy = dys[b];
          dx = dxs[b];
        end
      end
    end
    ady = (dy < 0) ? -dy : dy;
    adx = (dx < 0) ? -dx : dx;
    v = {4'h2, (dy >= 0) ? 8'h00 : 8'h7F, 4'(ady)};
    h = {4'h2, (dx >= 0) ? 8'hBF : 8'h3F, 4'(adx)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    #2;
    n_cmp++; if (mv_indx !== 5'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", mv_indx); end
    n_cmp++; if (resp !== 8'hA5) begin n_bad++; $display("FAIL reset_resp got %h want a5", resp); end
    n_cmp++; if (cmd !== 16'h1234) begin n_bad++; $display("FAIL reset_cmd got %h want 1234", cmd); end
    n_cmp++; if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", cmd_rdy); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Idle passthrough, with handshake inputs that must be ignored
  task automatic test_passthrough();
    logic [15:0] u;
    logic        r;
    for (int k = 0; k < 10; k++) begin
      u = 16'($urandom);
      r = 1'($urandom);
      cmd_UART = u;
      cmd_rdy_UART = r;
      clr_cmd_rdy = 1'($urandom);
      send_resp = 1'($urandom);
      #1;
      n_cmp++; if (cmd !== u) begin n_bad++; $display("FAIL idle_cmd got %h want %h", cmd, u); end
      n_cmp++; if (cmd_rdy !== r) begin n_bad++; $display("FAIL idle_rdy got %b want %b", cmd_rdy, r); end
      n_cmp++; if (resp !== 8'hA5) begin n_bad++; $display("FAIL idle_resp got %h want a5", resp); end
      tick();
    end
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
  endtask

  // Runs a tour from IDLE; stops at the VERT of move 'stop' if stop < 24
  task automatic run_tour(input int stop, input bit noise);
    logic [15:0] v, h, exp_cmd;
    logic        exp_rdy;
    logic [7:0]  exp_resp;
    int          wait_n;
    use_tour = 1'b1;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == stop) return;
      ref_legs(tour_moves[i], v, h);
      for (int p = 0; p < 4; p++) begin
        exp_cmd  = (p < 2) ? v : h;
        exp_rdy  = (p == 0) || (p == 2);
        exp_resp = (p == 3 && i == 23) ? 8'hA5 : 8'h5A;
        wait_n   = noise ? int'($urandom_range(0, 3)) : 0;
        for (int k = 0; k <= wait_n; k++) begin
          if (noise) begin
            start_tour = 1'($urandom);
            cmd_UART = 16'($urandom);
            cmd_rdy_UART = 1'($urandom);
            if (exp_rdy) send_resp = 1'($urandom);
            else clr_cmd_rdy = 1'($urandom);
          end
          if (k == wait_n) begin
            if (exp_rdy) clr_cmd_rdy = 1'b1;
            else send_resp = 1'b1;
          end
          #1;
          n_cmp++; if (cmd !== exp_cmd) begin n_bad++; $display("FAIL tour_cmd move %0d leg %0d got %h want %h", i, p, cmd, exp_cmd); end
          n_cmp++; if (cmd_rdy !== exp_rdy) begin n_bad++; $display("FAIL tour_rdy move %0d leg %0d got %b want %b", i, p, cmd_rdy, exp_rdy); end
          n_cmp++; if (resp !== exp_resp) begin n_bad++; $display("FAIL tour_resp move %0d leg %0d got %h want %h", i, p, resp, exp_resp); end
          n_cmp++; if (mv_indx !== 5'(i)) begin n_bad++; $display("FAIL tour_idx move %0d leg %0d got %0d want %0d", i, p, mv_indx, i); end
          tick();
          start_tour = 1'b0;
          clr_cmd_rdy = 1'b0;
          send_resp = 1'b0;
        end
      end
    end
    cmd_UART = 16'hBEEF;
    cmd_rdy_UART = 1'b0;
    #1;
    n_cmp++; if (cmd !== 16'hBEEF) begin n_bad++; $display("FAIL end_cmd got %h want beef", cmd); end
    n_cmp++; if (cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL end_rdy got %b want 0", cmd_rdy); end
    n_cmp++; if (resp !== 8'hA5) begin n_bad++; $display("FAIL end_resp got %h want a5", resp); end
    n_cmp++; if (mv_indx !== 5'd23) begin n_bad++; $display("FAIL end_idx got %0d want 23", mv_indx); end
  endtask

  task automatic test_directed_tour();
    for (int i = 0; i < 24; i++) tour_moves[i] = 8'(1 << (i % 8));
    run_tour(24, 1'b0);
    tick();
  endtask

  task automatic test_random_tour();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 24; i++) begin
        if ($urandom_range(0, 7) == 0) tour_moves[i] = 8'($urandom);
        else tour_moves[i] = 8'(1 << $urandom_range(0, 7));
      end
      run_tour(24, 1'b1);
      tick();
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] v, h;
    tour_moves[0] = 8'h10;
    ref_legs(8'h10, v, h);
    use_tour = 1'b1;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      n_cmp++; if (cmd !== v || cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL vwait_start got %h/%b want %h/0", cmd, cmd_rdy, v); end
      n_cmp++; if (mv_indx !== 5'd0 || resp !== 8'h5A) begin n_bad++; $display("FAIL vwait_state got %0d/%h want 0/5a", mv_indx, resp); end
    end
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    n_cmp++; if (cmd !== h || cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL vwait_horz got %h/%b want %h/1", cmd, cmd_rdy, h); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_tour();
    for (int i = 0; i < 24; i++) tour_moves[i] = 8'(1 << $urandom_range(0, 7));
    run_tour(5, 1'b1);
    n_cmp++; if (mv_indx !== 5'd5) begin n_bad++; $display("FAIL mid_idx got %0d want 5", mv_indx); end
    cmd_UART = 16'h4321;
    cmd_rdy_UART = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (mv_indx !== 5'd0) begin n_bad++; $display("FAIL rst_mid_idx got %0d want 0", mv_indx); end
    n_cmp++; if (cmd !== 16'h4321 || cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_cmd got %h/%b want 4321/0", cmd, cmd_rdy); end
    n_cmp++; if (resp !== 8'hA5) begin n_bad++; $display("FAIL rst_mid_resp got %h want a5", resp); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_not_onehot();
    use_tour = 1'b0;
    move_force = 8'h03;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    n_cmp++; if (cmd !== 16'h2000 || cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL bad_move_vert got %h/%b want 2000/1", cmd, cmd_rdy); end
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    n_cmp++; if (cmd !== 16'h2BF0 || cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL bad_move_horz got %h/%b want 2bf0/1", cmd, cmd_rdy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    use_tour = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    start_tour = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    cmd_UART = '0;
    cmd_rdy_UART = 1'b0;
    use_tour = 1'b1;
    move_force = '0;
    for (int i = 0; i < 32; i++) tour_moves[i] = 8'h01;
    test_reset();
    test_passthrough();
    test_directed_tour();
    test_random_tour();
    test_start_ignored();
    test_reset_mid_tour();
    test_not_onehot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
